// File: rtl/debounce_ce_gen.sv
// Push-button conditioner: synchroniser, stable-count debounce FSM, and registered
// level / press / release outputs that feed a clock-enabled capture flop.
module debounce_ce_gen #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic Clk,
  input  logic reset,
  input  logic btn_in,
  input  logic enable,
  output logic btn_level,
  output logic ce_pulse,
  output logic rel_pulse,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   ce_q, ce_d;
  logic                   rel_q, rel_d;
  logic                   busy_q, busy_d;
  logic                   btn_sync;

  assign btn_sync = sync_q[SYNC_STAGES-1];
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], btn_in};

  always_ff @(posedge Clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      ce_q    <= 1'b0;
      rel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      ce_q    <= ce_d;
      rel_q   <= rel_d;
      busy_q  <= busy_d;
    end
  end

  // Any opposite sample during a wait drops back to the last stable state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulses are computed fresh each cycle, so they last exactly one clock.
  always_comb begin
    level_d = level_q;
    ce_d    = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      PRESS_WAIT: begin
        if (btn_sync && cnt_q == CNT_LAST) begin
          level_d = 1'b1;
          ce_d    = enable;
        end
      end
      RELEASE_WAIT: begin
        if (!btn_sync && cnt_q == CNT_LAST) begin
          level_d = 1'b0;
          rel_d   = enable;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
  end

  assign btn_level = level_q;
  assign ce_pulse  = ce_q;
  assign rel_pulse = rel_q;
  assign busy      = busy_q;

endmodule
